// File: rtl/trace_event_pkg.sv
// Shared types and constants for the per-core trace event extractor.
package trace_event_pkg;

  localparam logic [15:0] NOP_OPC_HI = 16'h1500;
  localparam logic [15:0] NOP_EXIT   = 16'd1;
  localparam logic [15:0] NOP_REPORT = 16'd2;
  localparam logic [15:0] NOP_PRINTF = 16'd3;
  localparam logic [15:0] NOP_PUTC   = 16'd4;

  // Timestamp field is sized for the widest supported TS_WIDTH; narrower stamps are zero-extended.
  localparam int TS_MAX = 64;

  typedef struct packed {
    logic [15:0]       id;
    logic [15:0]       code;
    logic [31:0]       value;
    logic [31:0]       pc;
    logic [TS_MAX-1:0] ts;
  } trace_event_t;

endpackage

// File: rtl/trace_event_fifo.sv
// First-word-fall-through FIFO of event records; a push into a full FIFO succeeds if a pop is
// accepted in the same cycle.
module trace_event_fifo
  import trace_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_event_t din,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output trace_event_t dout
);

  localparam int AW = $clog2(DEPTH);

  trace_event_t   mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/trace_event_extract.sv
// Decodes l.nop K retirements from one core's trace port into timestamped event records,
// shadowing r3 as the event payload, and streams them out through a small FIFO.
module trace_event_extract
  import trace_event_pkg::*;
#(
  parameter int ID         = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trace_enable,
  input  logic [31:0]          trace_pc,
  input  logic [31:0]          trace_insn,
  input  logic                 trace_wben,
  input  logic [4:0]           trace_wbreg,
  input  logic [31:0]          trace_wbdata,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [15:0]          event_id,
  output logic [15:0]          event_code,
  output logic [31:0]          event_value,
  output logic [31:0]          event_pc,
  output logic [TS_WIDTH-1:0]  event_time,
  output logic                 terminated,
  output logic [CNT_WIDTH-1:0] drop_count
);

  logic [31:0]       r3;
  logic [TS_WIDTH-1:0] timestamp;
  logic              capture, fifo_full, fifo_empty, drop;
  trace_event_t      rec_in, rec_out;

  assign capture = trace_enable && (trace_insn[31:16] == NOP_OPC_HI) &&
                   (trace_insn[15:0] != 16'd0) && !terminated;
  // A pop frees a slot in the same cycle, so only full-without-pop loses the record.
  assign drop    = capture && fifo_full && !event_ready;

  // r3 is the pre-update shadow: a same-cycle write to r3 is seen only by later nops.
  assign rec_in = '{id:    16'(ID),
                    code:  trace_insn[15:0],
                    value: r3,
                    pc:    trace_pc,
                    ts:    TS_MAX'(timestamp)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3         <= '0;
      timestamp  <= '0;
      terminated <= 1'b0;
      drop_count <= '0;
    end else begin
      timestamp <= timestamp + TS_WIDTH'(1);
      if (trace_enable && trace_wben && (trace_wbreg == 5'd3)) r3 <= trace_wbdata;
      if (capture && (trace_insn[15:0] == NOP_EXIT)) terminated <= 1'b1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

  trace_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (rec_in),
    .full  (fifo_full),
    .pop   (event_ready),
    .empty (fifo_empty),
    .dout  (rec_out)
  );

  assign event_valid = !fifo_empty;
  assign event_id    = rec_out.id;
  assign event_code  = rec_out.code;
  assign event_value = rec_out.value;
  assign event_pc    = rec_out.pc;
  assign event_time  = rec_out.ts[TS_WIDTH-1:0];

  generate
    if (TS_WIDTH < TS_MAX) begin : g_ts_pad
      logic unused_ts_hi;
      assign unused_ts_hi = ^rec_out.ts[TS_MAX-1:TS_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_trace_event_extract.sv
// Directed scenarios for trace_event_extract with hand-computed expected records.
module tb_trace_event_extract;

  localparam int ID = 7, DEPTH = 8, TSW = 32, CW = 2;

  logic            clk = 1'b0, rst = 1'b1;
  logic            trace_enable = 1'b0, trace_wben = 1'b0, event_ready = 1'b0;
  logic [31:0]     trace_pc = '0, trace_insn = '0, trace_wbdata = '0;
  logic [4:0]      trace_wbreg = '0;
  logic            event_valid, terminated;
  logic [15:0]     event_id, event_code;
  logic [31:0]     event_value, event_pc;
  logic [TSW-1:0]  event_time;
  logic [CW-1:0]   drop_count;

  int vectors = 0, errors = 0;

  trace_event_extract #(.ID(ID), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .trace_enable(trace_enable), .trace_pc(trace_pc),
    .trace_insn(trace_insn), .trace_wben(trace_wben), .trace_wbreg(trace_wbreg),
    .trace_wbdata(trace_wbdata), .event_valid(event_valid), .event_ready(event_ready),
    .event_id(event_id), .event_code(event_code), .event_value(event_value),
    .event_pc(event_pc), .event_time(event_time), .terminated(terminated),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Presents one retirement for a single cycle; returns on the following negedge.
  task automatic retire(input logic [31:0] insn, input logic [31:0] pc, input logic wben,
                        input logic [4:0] wreg, input logic [31:0] data);
    trace_enable = 1'b1; trace_insn = insn; trace_pc = pc;
    trace_wben = wben; trace_wbreg = wreg; trace_wbdata = data;
    @(negedge clk);
    trace_enable = 1'b0; trace_wben = 1'b0;
  endtask

  task automatic pop_one();
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({event_valid, terminated, drop_count, event_id, event_code, event_value, event_pc, event_time} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b term=%0b drop=%0d id=%h code=%h val=%h pc=%h time=%h, want all 0",
               event_valid, terminated, drop_count, event_id, event_code, event_value, event_pc, event_time);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    retire(32'h9c600041, 32'h0fc, 1'b1, 5'd3, 32'h41);
    vectors++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL basic_no_event_on_write: valid=%0b want 0", event_valid); end
    retire(32'h15000004, 32'h100, 1'b0, 5'd0, 32'h0);
    vectors++;
    if ({event_valid, event_id, event_code, event_value, event_pc} !== {1'b1, 16'd7, 16'd4, 32'h41, 32'h100}) begin
      errors++;
      $display("FAIL basic_record: valid=%0b id=%0d code=%0d val=%h pc=%h, want 1 7 4 00000041 00000100",
               event_valid, event_id, event_code, event_value, event_pc);
    end
    vectors++;
    if (event_time !== 32'd1) begin errors++; $display("FAIL basic_time: got %0d want 1", event_time); end
    pop_one();
    vectors++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_empty: valid=%0b want 0", event_valid); end
  endtask

  task automatic test_same_cycle_r3();
    logic [31:0] exp_val [2];
    logic [31:0] exp_pc  [2];
    exp_val[0] = 32'h41; exp_pc[0] = 32'h110;
    exp_val[1] = 32'h55; exp_pc[1] = 32'h114;
    retire(32'h15000004, 32'h110, 1'b1, 5'd3, 32'h55);
    retire(32'h15000004, 32'h114, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({event_valid, event_value, event_pc} !== {1'b1, exp_val[i], exp_pc[i]}) begin
        errors++;
        $display("FAIL same_cycle_r3[%0d]: valid=%0b val=%h pc=%h, want 1 %h %h",
                 i, event_valid, event_value, event_pc, exp_val[i], exp_pc[i]);
      end
      pop_one();
    end
    // Plain nop (K=0) and a disabled trace slot must not create events.
    retire(32'h15000000, 32'h118, 1'b0, 5'd0, 32'h0);
    trace_insn = 32'h15000004; trace_pc = 32'h11c;
    @(negedge clk);
    vectors++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL k0_or_disabled: valid=%0b want 0", event_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) retire(32'h15000004, 32'h200 + 32'(4*i), 1'b0, 5'd0, 32'h0);
    vectors++;
    if (drop_count !== 2'd3) begin errors++; $display("FAIL overflow_drop_saturate: got %0d want 3", drop_count); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({event_valid, event_code, event_value, event_pc} !== {1'b1, 16'd4, 32'h55, 32'h200 + 32'(4*i)}) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: valid=%0b code=%0d val=%h pc=%h, want 1 4 00000055 %h",
                 i, event_valid, event_code, event_value, event_pc, 32'h200 + 32'(4*i));
      end
      pop_one();
    end
    vectors++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL overflow_empty: valid=%0b want 0", event_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_pc;
    logic [15:0] exp_code;
    for (int i = 0; i < 8; i++) retire(32'h15000004, 32'h300 + 32'(4*i), 1'b0, 5'd0, 32'h0);
    vectors++;
    if (event_pc !== 32'h300) begin errors++; $display("FAIL full_head: pc=%h want 00000300", event_pc); end
    event_ready = 1'b1;
    retire(32'h15000003, 32'h400, 1'b0, 5'd0, 32'h0);
    event_ready = 1'b0;
    vectors++;
    if (drop_count !== 2'd3) begin errors++; $display("FAIL full_no_drop: drop=%0d want 3", drop_count); end
    for (int i = 0; i < 8; i++) begin
      exp_pc   = (i < 7) ? 32'h304 + 32'(4*i) : 32'h400;
      exp_code = (i < 7) ? 16'd4 : 16'd3;
      vectors++;
      if ({event_valid, event_code, event_pc} !== {1'b1, exp_code, exp_pc}) begin
        errors++;
        $display("FAIL full_order[%0d]: valid=%0b code=%0d pc=%h, want 1 %0d %h",
                 i, event_valid, event_code, event_pc, exp_code, exp_pc);
      end
      pop_one();
    end
    vectors++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL full_empty: valid=%0b want 0", event_valid); end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 3; i++) retire(32'h15000002, 32'h500 + 32'(4*i), 1'b0, 5'd0, 32'h0);
    vectors++;
    if (event_valid !== 1'b1) begin errors++; $display("FAIL midburst_queued: valid=%0b want 1", event_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({event_valid, drop_count, terminated} !== '0) begin
      errors++;
      $display("FAIL midburst_async_clear: valid=%0b drop=%0d term=%0b, want 0 0 0", event_valid, drop_count, terminated);
    end
    @(negedge clk);
    rst = 1'b0;
    retire(32'h15000004, 32'h600, 1'b0, 5'd0, 32'h0);
    vectors++;
    if ({event_valid, event_value, event_pc, event_time} !== {1'b1, 32'h0, 32'h600, 32'd0}) begin
      errors++;
      $display("FAIL midburst_restart: valid=%0b val=%h pc=%h time=%0d, want 1 00000000 00000600 0",
               event_valid, event_value, event_pc, event_time);
    end
    pop_one();
  endtask

  task automatic test_exit();
    retire(32'h15000001, 32'h700, 1'b0, 5'd0, 32'h0);
    vectors++;
    if (terminated !== 1'b1) begin errors++; $display("FAIL exit_terminated: got %0b want 1", terminated); end
    retire(32'h15000004, 32'h704, 1'b0, 5'd0, 32'h0);
    vectors++;
    if ({event_valid, event_code, event_pc} !== {1'b1, 16'd1, 32'h700}) begin
      errors++;
      $display("FAIL exit_record: valid=%0b code=%0d pc=%h, want 1 1 00000700", event_valid, event_code, event_pc);
    end
    pop_one();
    vectors++;
    if ({event_valid, terminated} !== 2'b01) begin
      errors++;
      $display("FAIL exit_putc_ignored: valid=%0b term=%0b, want 0 1", event_valid, terminated);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle_r3();
    test_overflow();
    test_full_push_pop();
    test_reset_midburst();
    test_exit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
